// File: rtl/wb_controller.sv
// Write-back controller: buffers {dest, data} results in a 2-entry FIFO and
// issues one registered write strobe per result to a downstream register bank.
module wb_controller #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned NUM_REGS  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_dest,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 stall,
  input  logic                 flush,
  output logic                 write_control,
  output logic [NUM_REGS-1:0]  active_enable,
  output logic [BUS_WIDTH-1:0] out_data,
  output logic [1:0]           occupancy
);

  localparam int unsigned DEPTH  = 2;
  localparam int unsigned DEST_W = 2;
  localparam int unsigned CNT_W  = 2;

  logic [DEST_W-1:0]    r_dest [DEPTH];
  logic [BUS_WIDTH-1:0] r_data [DEPTH];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_write_control;
  logic [NUM_REGS-1:0]  r_active_enable;
  logic [BUS_WIDTH-1:0] r_out_data;

  logic                 w_full;
  logic                 w_push;
  logic                 w_pop;
  logic [DEST_W-1:0]    w_head_dest;
  logic [BUS_WIDTH-1:0] w_head_data;
  logic [NUM_REGS-1:0]  w_onehot;

  // Flush wins over both push and pop; stall only blocks the pop side.
  always_comb begin
    w_full      = (r_count == CNT_W'(DEPTH));
    w_push      = in_valid && !w_full && !flush;
    w_pop       = (r_count != '0) && !stall && !flush;
    w_head_dest = r_dest[r_rd_ptr];
    w_head_data = r_data[r_rd_ptr];
  end

  // Destinations beyond the register bank decode to no select line.
  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (32'(w_head_dest) == i) begin
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_wr_ptr] <= in_dest;
      r_data[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-back outputs are registered at the pop edge and last one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_write_control <= 1'b0;
      r_active_enable <= '0;
      r_out_data      <= '0;
    end else begin
      r_write_control <= w_pop;
      r_active_enable <= w_pop ? w_onehot : '0;
      if (w_pop) begin
        r_out_data <= w_head_data;
      end
    end
  end

  assign in_ready      = (r_count != CNT_W'(DEPTH));
  assign occupancy     = r_count;
  assign write_control = r_write_control;
  assign active_enable = r_active_enable;
  assign out_data      = r_out_data;

endmodule
